// File: rtl/spi_acq_sequencer.sv
// Single-pixel-imaging acquisition sequencer.
// For each pattern: trigger the DMD, wait for it to settle, count photons
// over a gate window and write the count to memory. After the last pattern
// the stored counts are streamed to the host over a valid/ready handshake.
module spi_acq_sequencer #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned TRIG_CYCLES = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W:0]   num_patterns_i,
    input  logic [15:0]       settle_cycles_i,
    input  logic [23:0]       integ_cycles_i,
    input  logic              photon_i,
    output logic              dmd_trig_o,
    output logic              gate_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_waddr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [ADDR_W-1:0] mem_raddr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              tx_valid_o,
    output logic [DATA_W-1:0] tx_data_o,
    input  logic              tx_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              sat_o
);

    typedef enum logic [3:0] {
        StIdle, StTrig, StSettle, StInteg, StStore, StRaddr, StRdata, StSend, StDone
    } state_e;

    localparam logic [ADDR_W:0]   NpatMax      = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [DATA_W-1:0] CountMax     = '1;
    localparam logic [DATA_W-1:0] CountNearMax = {{(DATA_W-1){1'b1}}, 1'b0};
    localparam logic [23:0]       TrigLoad     = 24'(TRIG_CYCLES - 1);

    state_e              state_q;
    logic [ADDR_W:0]     npat_q;
    logic [15:0]         settle_q;
    logic [23:0]         integ_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [23:0]         timer_q;
    logic [DATA_W-1:0]   count_q;
    logic [DATA_W-1:0]   tx_data_q;
    logic                trig_q, gate_q, we_q, tx_valid_q, done_q, sat_q;

    logic                last_idx, start_ok;
    logic [ADDR_W:0]     npat_m1;
    logic [23:0]         integ_load, settle_load;

    // Decode helpers from the latched run configuration.
    always_comb begin
        npat_m1     = npat_q - (ADDR_W + 1)'(1);
        last_idx    = ({1'b0, idx_q} == npat_m1);
        start_ok    = (num_patterns_i != '0) && (num_patterns_i <= NpatMax);
        // A zero-length gate still gets one counting cycle.
        integ_load  = (integ_q == 24'd0) ? 24'd0 : integ_q - 24'd1;
        settle_load = {8'd0, settle_q} - 24'd1;
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            npat_q     <= '0;
            settle_q   <= '0;
            integ_q    <= '0;
            idx_q      <= '0;
            timer_q    <= '0;
            count_q    <= '0;
            tx_data_q  <= '0;
            trig_q     <= 1'b0;
            gate_q     <= 1'b0;
            we_q       <= 1'b0;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            sat_q      <= 1'b0;
        end else if (abort_i) begin
            // sat and memory contents deliberately survive an abort.
            state_q    <= StIdle;
            trig_q     <= 1'b0;
            gate_q     <= 1'b0;
            we_q       <= 1'b0;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            we_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i && start_ok) begin
                        npat_q   <= num_patterns_i;
                        settle_q <= settle_cycles_i;
                        integ_q  <= integ_cycles_i;
                        idx_q    <= '0;
                        sat_q    <= 1'b0;
                        timer_q  <= TrigLoad;
                        trig_q   <= 1'b1;
                        state_q  <= StTrig;
                    end
                end
                StTrig: begin
                    if (timer_q == 24'd0) begin
                        trig_q <= 1'b0;
                        if (settle_q != 16'd0) begin
                            timer_q <= settle_load;
                            state_q <= StSettle;
                        end else begin
                            timer_q <= integ_load;
                            count_q <= '0;
                            gate_q  <= 1'b1;
                            state_q <= StInteg;
                        end
                    end else begin
                        timer_q <= timer_q - 24'd1;
                    end
                end
                StSettle: begin
                    if (timer_q == 24'd0) begin
                        timer_q <= integ_load;
                        count_q <= '0;
                        gate_q  <= 1'b1;
                        state_q <= StInteg;
                    end else begin
                        timer_q <= timer_q - 24'd1;
                    end
                end
                StInteg: begin
                    if (photon_i && (count_q != CountMax)) begin
                        count_q <= count_q + DATA_W'(1);
                        if (count_q == CountNearMax) sat_q <= 1'b1;
                    end
                    if (timer_q == 24'd0) begin
                        gate_q  <= 1'b0;
                        we_q    <= 1'b1;
                        state_q <= StStore;
                    end else begin
                        timer_q <= timer_q - 24'd1;
                    end
                end
                StStore: begin
                    if (last_idx) begin
                        idx_q   <= '0;
                        state_q <= StRaddr;
                    end else begin
                        idx_q   <= idx_q + ADDR_W'(1);
                        timer_q <= TrigLoad;
                        trig_q  <= 1'b1;
                        state_q <= StTrig;
                    end
                end
                StRaddr: state_q <= StRdata;
                StRdata: begin
                    tx_data_q  <= mem_rdata_i;
                    tx_valid_q <= 1'b1;
                    state_q    <= StSend;
                end
                StSend: begin
                    if (tx_ready_i) begin
                        tx_valid_q <= 1'b0;
                        if (last_idx) begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            idx_q   <= idx_q + ADDR_W'(1);
                            state_q <= StRaddr;
                        end
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // Write/read addresses and write data come straight from the index and count registers.
    assign dmd_trig_o  = trig_q;
    assign gate_o      = gate_q;
    assign mem_we_o    = we_q;
    assign mem_waddr_o = idx_q;
    assign mem_wdata_o = count_q;
    assign mem_raddr_o = idx_q;
    assign tx_valid_o  = tx_valid_q;
    assign tx_data_o   = tx_data_q;
    assign busy_o      = (state_q != StIdle);
    assign done_o      = done_q;
    assign sat_o       = sat_q;

endmodule

// File: tb/tb_spi_acq_sequencer.sv
// Directed bench for spi_acq_sequencer (ADDR_W=4 so the full-depth run stays short).
module tb_spi_acq_sequencer;

    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0, abort = 1'b0, photon = 1'b0, tx_ready = 1'b0;
    logic [AW:0]   npat = '0;
    logic [15:0]   settle = '0;
    logic [23:0]   integ = '0;
    logic          dmd_trig, gate, mem_we, tx_valid, busy, done, sat;
    logic [AW-1:0] mem_waddr, mem_raddr;
    logic [DW-1:0] mem_wdata, mem_rdata, tx_data;

    spi_acq_sequencer #(.ADDR_W(AW), .DATA_W(DW), .TRIG_CYCLES(4)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
        .num_patterns_i(npat), .settle_cycles_i(settle), .integ_cycles_i(integ),
        .photon_i(photon), .dmd_trig_o(dmd_trig), .gate_o(gate), .mem_we_o(mem_we),
        .mem_waddr_o(mem_waddr), .mem_wdata_o(mem_wdata), .mem_raddr_o(mem_raddr),
        .mem_rdata_i(mem_rdata), .tx_valid_o(tx_valid), .tx_data_o(tx_data),
        .tx_ready_i(tx_ready), .busy_o(busy), .done_o(done), .sat_o(sat)
    );

    always #5 clk = ~clk;

    // Count memory model: synchronous write, one-cycle read latency.
    logic [DW-1:0] mem [1 << AW];
    always @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        mem_rdata <= mem[mem_raddr];
    end

    int pass_cnt = 0, chk_cnt = 0;
    int ph_mode = 0;   // 0 low, 1 high, 2 toggle, 3 (k+1) photons in gate of pattern k
    int stall = 0;
    int ph_pat = 0, ph_gcnt = 0, rdy_wait = 0;

    // Photon source, driven just after each edge.
    initial begin
        forever begin
            @(posedge clk); #1;
            case (ph_mode)
                0: photon = 1'b0;
                1: photon = 1'b1;
                2: photon = ~photon;
                default: begin
                    if (gate) begin
                        photon = (ph_gcnt <= ph_pat);
                        ph_gcnt++;
                    end else begin
                        if (ph_gcnt != 0) ph_pat++;
                        ph_gcnt = 0;
                        photon = 1'b0;
                    end
                end
            endcase
        end
    end

    // Host ready: always ready, or 7 stalled cycles per presented word.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (stall == 0) tx_ready = 1'b1;
            else if (tx_valid) begin
                if (rdy_wait == 7) begin tx_ready = 1'b1; rdy_wait = 0; end
                else begin tx_ready = 1'b0; rdy_wait++; end
            end else begin
                tx_ready = 1'b0; rdy_wait = 0;
            end
        end
    end

    // Observation logs, sampled on the falling edge.
    int            trig_w[$], gate_w[$], gap_q[$];
    logic [AW-1:0] wa_q[$];
    logic [DW-1:0] wd_q[$], tx_q[$];
    int            trig_run = 0, gate_run = 0, gap = 0, gap_on = 0, done_cnt = 0, stab_err = 0;
    logic          prev_valid = 0, prev_hs = 0;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (dmd_trig) trig_run++;
        else if (trig_run != 0) begin
            trig_w.push_back(trig_run); trig_run = 0; gap_on = 1; gap = 0;
        end
        if (gate) begin
            if (gate_run == 0 && gap_on != 0) begin gap_q.push_back(gap); gap_on = 0; end
            gate_run++;
        end else begin
            if (gate_run != 0) begin gate_w.push_back(gate_run); gate_run = 0; end
            if (gap_on != 0) gap++;
        end
        if (mem_we) begin wa_q.push_back(mem_waddr); wd_q.push_back(mem_wdata); end
        if (tx_valid && tx_ready) tx_q.push_back(tx_data);
        if (done) done_cnt++;
        if (prev_valid && !prev_hs && (!tx_valid || tx_data !== prev_data)) stab_err++;
        prev_valid = tx_valid; prev_data = tx_data; prev_hs = tx_valid && tx_ready;
    end

    task automatic clear_logs();
        trig_w.delete(); gate_w.delete(); gap_q.delete();
        wa_q.delete(); wd_q.delete(); tx_q.delete();
        done_cnt = 0; stab_err = 0; gap_on = 0;
    endtask

    task automatic launch(input int n, input int s, input int g);
        @(posedge clk); #1;
        npat = (AW + 1)'(n); settle = 16'(s); integ = 24'(g); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max, output bit timed_out);
        int n = 0;
        do begin @(negedge clk); n++; end while (busy && n < max);
        timed_out = busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if ({dmd_trig, gate, mem_we, tx_valid, busy, done, sat} !== 7'b0)
            $display("FAIL reset_ctrl got %b want 0", {dmd_trig, gate, mem_we, tx_valid, busy, done, sat});
        else pass_cnt++;
        chk_cnt++;
        if ({mem_waddr, mem_raddr, mem_wdata, tx_data} !== '0)
            $display("FAIL reset_data got %h want 0", {mem_waddr, mem_raddr, mem_wdata, tx_data});
        else pass_cnt++;
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_idle busy got %b want 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        bit to;
        clear_logs(); ph_mode = 2; stall = 0;
        launch(3, 2, 10);
        wait_idle(2000, to);
        chk_cnt++;
        if (to) $display("FAIL basic_timeout busy still 1 want 0"); else pass_cnt++;
        chk_cnt++;
        if (trig_w.size() != 3 || wa_q.size() != 3 || tx_q.size() != 3)
            $display("FAIL basic_sizes trig=%0d wr=%0d tx=%0d want 3/3/3",
                     trig_w.size(), wa_q.size(), tx_q.size());
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            if (i < trig_w.size() && i < gate_w.size() && i < gap_q.size()) begin
                chk_cnt++;
                if (trig_w[i] != 4 || gate_w[i] != 10 || gap_q[i] != 2)
                    $display("FAIL basic_timing[%0d] trig=%0d gate=%0d gap=%0d want 4/10/2",
                             i, trig_w[i], gate_w[i], gap_q[i]);
                else pass_cnt++;
            end
            if (i < wa_q.size() && i < tx_q.size()) begin
                chk_cnt++;
                if (wa_q[i] !== AW'(i) || wd_q[i] !== 16'd5 || tx_q[i] !== 16'd5)
                    $display("FAIL basic_word[%0d] addr=%0d data=%0d tx=%0d want %0d/5/5",
                             i, wa_q[i], wd_q[i], tx_q[i], i);
                else pass_cnt++;
            end
        end
        chk_cnt++;
        if (done_cnt != 1 || sat !== 1'b0)
            $display("FAIL basic_done done_cnt=%0d sat=%b want 1/0", done_cnt, sat);
        else pass_cnt++;
    endtask

    task automatic test_min_integ();
        bit to;
        clear_logs(); ph_mode = 1; stall = 0;
        launch(2, 0, 0);
        wait_idle(2000, to);
        chk_cnt++;
        if (to || gate_w.size() != 2 || gap_q.size() != 2)
            $display("FAIL mininteg_sizes to=%0d gates=%0d gaps=%0d want 0/2/2",
                     to, gate_w.size(), gap_q.size());
        else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            if (i < gate_w.size() && i < gap_q.size() && i < wd_q.size() && i < tx_q.size()) begin
                chk_cnt++;
                if (gate_w[i] != 1 || gap_q[i] != 0 || wd_q[i] !== 16'd1 || tx_q[i] !== 16'd1)
                    $display("FAIL mininteg[%0d] gate=%0d gap=%0d data=%0d tx=%0d want 1/0/1/1",
                             i, gate_w[i], gap_q[i], wd_q[i], tx_q[i]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_saturation();
        bit to;
        clear_logs(); ph_mode = 1; stall = 0;
        launch(1, 0, 70000);
        wait_idle(80000, to);
        chk_cnt++;
        if (to || wd_q.size() != 1 || tx_q.size() != 1)
            $display("FAIL sat_sizes to=%0d wr=%0d tx=%0d want 0/1/1", to, wd_q.size(), tx_q.size());
        else pass_cnt++;
        if (wd_q.size() == 1 && tx_q.size() == 1 && gate_w.size() == 1) begin
            chk_cnt++;
            if (wd_q[0] !== 16'hFFFF || tx_q[0] !== 16'hFFFF || gate_w[0] != 70000)
                $display("FAIL sat_value data=%h tx=%h gate=%0d want ffff/ffff/70000",
                         wd_q[0], tx_q[0], gate_w[0]);
            else pass_cnt++;
        end
        repeat (3) @(negedge clk);
        chk_cnt++;
        if (sat !== 1'b1) $display("FAIL sat_sticky got %b want 1", sat); else pass_cnt++;
    endtask

    task automatic test_stall();
        bit to;
        clear_logs(); ph_mode = 3; ph_pat = 0; ph_gcnt = 0; stall = 1;
        launch(4, 1, 8);
        @(negedge clk);
        chk_cnt++;
        if (sat !== 1'b0 || busy !== 1'b1)
            $display("FAIL stall_start sat=%b busy=%b want 0/1", sat, busy);
        else pass_cnt++;
        wait_idle(3000, to);
        chk_cnt++;
        if (to || tx_q.size() != 4 || wd_q.size() != 4 || done_cnt != 1 || stab_err != 0)
            $display("FAIL stall_summary to=%0d tx=%0d wr=%0d done=%0d unstable=%0d want 0/4/4/1/0",
                     to, tx_q.size(), wd_q.size(), done_cnt, stab_err);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            if (i < tx_q.size() && i < wd_q.size()) begin
                chk_cnt++;
                if (tx_q[i] !== 16'(i + 1) || wd_q[i] !== 16'(i + 1))
                    $display("FAIL stall_word[%0d] tx=%0d wr=%0d want %0d", i, tx_q[i], wd_q[i], i + 1);
                else pass_cnt++;
            end
        end
        stall = 0;
    endtask

    task automatic test_abort();
        bit to;
        int n = 0;
        clear_logs(); ph_mode = 2; stall = 0;
        launch(3, 0, 20);
        while (!(wa_q.size() == 2 && gate) && n < 2000) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        chk_cnt++;
        if (gate !== 1'b1) $display("FAIL abort_setup gate=%b want 1", gate); else pass_cnt++;
        @(posedge clk); #1 abort = 1'b1; start = 1'b1;
        @(posedge clk); #1 abort = 1'b0; start = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if ({dmd_trig, gate, mem_we, tx_valid, busy, done} !== 6'b0)
            $display("FAIL abort_outputs got %b want 0", {dmd_trig, gate, mem_we, tx_valid, busy, done});
        else pass_cnt++;
        repeat (4) @(negedge clk);
        chk_cnt++;
        if (busy !== 1'b0 || done_cnt != 0)
            $display("FAIL abort_quiet busy=%b done=%0d want 0/0", busy, done_cnt);
        else pass_cnt++;
        clear_logs();
        launch(2, 0, 4);
        wait_idle(2000, to);
        chk_cnt++;
        if (to || wa_q.size() != 2 || tx_q.size() != 2 || done_cnt != 1)
            $display("FAIL abort_rerun to=%0d wr=%0d tx=%0d done=%0d want 0/2/2/1",
                     to, wa_q.size(), tx_q.size(), done_cnt);
        else pass_cnt++;
        if (wa_q.size() == 2 && tx_q.size() == 2) begin
            chk_cnt++;
            if (wa_q[0] !== 4'd0 || wa_q[1] !== 4'd1 || tx_q[0] !== 16'd2 || tx_q[1] !== 16'd2)
                $display("FAIL abort_rerun_words addr=%0d,%0d tx=%0d,%0d want 0,1 2,2",
                         wa_q[0], wa_q[1], tx_q[0], tx_q[1]);
            else pass_cnt++;
        end
    endtask

    task automatic test_ignored();
        bit to;
        clear_logs(); ph_mode = 2; stall = 0;
        launch(0, 0, 3);
        repeat (3) @(negedge clk);
        chk_cnt++;
        if (busy !== 1'b0) $display("FAIL ignore_zero busy=%b want 0", busy); else pass_cnt++;
        launch(17, 0, 3);
        repeat (3) @(negedge clk);
        chk_cnt++;
        if (busy !== 1'b0 || trig_w.size() != 0)
            $display("FAIL ignore_over busy=%b trig=%0d want 0/0", busy, trig_w.size());
        else pass_cnt++;
        launch(1, 0, 30);
        repeat (10) @(negedge clk);
        launch(3, 0, 5);
        wait_idle(2000, to);
        chk_cnt++;
        if (to || wd_q.size() != 1 || tx_q.size() != 1 || done_cnt != 1 || gate_w.size() != 1)
            $display("FAIL ignore_busy to=%0d wr=%0d tx=%0d done=%0d gates=%0d want 0/1/1/1/1",
                     to, wd_q.size(), tx_q.size(), done_cnt, gate_w.size());
        else pass_cnt++;
        if (wd_q.size() == 1 && gate_w.size() == 1) begin
            chk_cnt++;
            if (wd_q[0] !== 16'd15 || gate_w[0] != 30)
                $display("FAIL ignore_busy_cfg data=%0d gate=%0d want 15/30", wd_q[0], gate_w[0]);
            else pass_cnt++;
        end
    endtask

    task automatic test_boundary();
        bit to;
        clear_logs(); ph_mode = 1; stall = 0;
        launch(16, 0, 1);
        wait_idle(3000, to);
        chk_cnt++;
        if (to || wa_q.size() != 16 || tx_q.size() != 16 || done_cnt != 1)
            $display("FAIL bound_sizes to=%0d wr=%0d tx=%0d done=%0d want 0/16/16/1",
                     to, wa_q.size(), tx_q.size(), done_cnt);
        else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            if (i < wa_q.size() && i < tx_q.size()) begin
                chk_cnt++;
                if (wa_q[i] !== AW'(i) || wd_q[i] !== 16'd1 || tx_q[i] !== 16'd1)
                    $display("FAIL bound_word[%0d] addr=%0d data=%0d tx=%0d want %0d/1/1",
                             i, wa_q[i], wd_q[i], tx_q[i], i);
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_min_integ();
        test_saturation();
        test_stall();
        test_abort();
        test_ignored();
        test_boundary();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/spi_acq_sequencer.md
Name: spi_acq_sequencer

Overview:
Sequences one single-pixel-imaging acquisition run. For each DMD pattern it fires the DMD trigger, waits a settle time, counts photon pulses over an integration window, and writes the count into the pattern-count memory. After the last pattern it streams the stored counts to the host transmitter over a valid/ready handshake. It sits between the photon-counter front end, the DMD trigger output, the count memory and the host UART TX.

Parameters:
ADDR_W, 10, count-memory address width (depth 2^ADDR_W)
DATA_W, 16, photon count / memory word width
TRIG_CYCLES, 4, dmd_trig pulse width in clk cycles (>=1)

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse, begins run (honoured only in IDLE)
abort  in  1  synchronous abort, returns to IDLE from any state
num_patterns  in  ADDR_W+1  patterns per run, 1..2^ADDR_W, latched on start
settle_cycles  in  16  cycles between trigger end and gate open, 0 allowed
integ_cycles  in  24  gate length in cycles, 0 treated as 1
photon  in  1  photon pulse, already synchronised, one cycle per photon
dmd_trig  out  1  DMD advance trigger
gate  out  1  high while counting
mem_we  out  1  memory write strobe
mem_waddr  out  ADDR_W  write address
mem_wdata  out  DATA_W  write data
mem_raddr  out  ADDR_W  read address
mem_rdata  in  DATA_W  read data, valid 1 cycle after mem_raddr
tx_valid  out  1  host word valid
tx_data  out  DATA_W  host word
tx_ready  in  1  host accepts word when tx_valid&tx_ready
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on normal run completion
sat  out  1  sticky: any count in this run saturated; cleared on start

Behaviour:
- Reset: state IDLE; all outputs 0; pattern index, counters, latched config cleared.
- States: IDLE, TRIG, SETTLE, INTEG, STORE, RADDR, RDATA, SEND, DONE.
- IDLE: start with num_patterns in 1..2^ADDR_W -> latch config, idx=0, sat=0, -> TRIG. num_patterns 0 or >2^ADDR_W: start ignored, stay IDLE.
- TRIG: dmd_trig=1 for exactly TRIG_CYCLES cycles -> SETTLE (settle_cycles>0) else INTEG.
- SETTLE: exactly settle_cycles cycles, outputs idle -> INTEG.
- INTEG: gate=1 for max(integ_cycles,1) cycles; count cleared on entry; each cycle with photon=1 adds 1; saturates at 2^DATA_W-1 and sets sat. Photons outside INTEG are ignored.
- STORE: one cycle, mem_we=1, mem_waddr=idx, mem_wdata=count. If idx==num_patterns-1 -> idx=0, RADDR; else idx+1 -> TRIG.
- RADDR: mem_raddr=idx for one cycle -> RDATA.
- RDATA: capture mem_rdata into tx_data, tx_valid=1 -> SEND.
- SEND: hold tx_valid, tx_data stable until tx_ready. On handshake: tx_valid drops next cycle; idx==num_patterns-1 -> DONE, else idx+1 -> RADDR. tx_ready while tx_valid=0 has no effect.
- DONE: done=1 for one cycle -> IDLE.
- Words sent in index order 0..num_patterns-1; per-word minimum 3 cycles (RADDR, RDATA, SEND).
- start while busy: ignored. Config input changes during a run: no effect.
- abort (or rst) in any state: next cycle IDLE, dmd_trig/gate/mem_we/tx_valid/busy = 0, no done pulse; memory contents untouched. abort has priority over start in the same cycle. sat retains its value on abort, cleared on rst.
- Boundary: num_patterns=2^ADDR_W writes addresses 0..2^ADDR_W-1, no wrap; idx never exceeds num_patterns-1.

Test Plan:
- num_patterns=3, settle=2, integ=10, photon high 5 of 10 INTEG cycles each pattern -> dmd_trig pulses 4 cycles wide, 3 writes addr 0,1,2 data 5, tx words 5,5,5, done once, busy low after.
- integ=0, photon constantly 1 -> gate exactly 1 cycle, stored count 1; settle=0 -> INTEG directly follows TRIG.
- DATA_W=16, integ=70000, photon always 1 -> stored 0xFFFF, sat=1 until next start.
- Readout with tx_ready low 7 cycles per word -> tx_data stable while tx_valid high, no word lost or duplicated, order 0..N-1.
- abort mid-INTEG of pattern 2 -> IDLE next cycle, all outputs 0, no done; new start runs correctly from idx 0.
- start with num_patterns=0, and start during busy -> both ignored, no state change.
